// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared register map and bit indices for timer_irq_gen
package timer_pkg;

    // Word-aligned register offsets within the 5-bit byte address space
    localparam logic [4:0] TMR_CTRL   = 5'h00;
    localparam logic [4:0] TMR_COUNT  = 5'h04;
    localparam logic [4:0] TMR_CMP    = 5'h08;
    localparam logic [4:0] TMR_STATUS = 5'h0C;
    localparam logic [4:0] TMR_PRESC  = 5'h10;

    // CTRL bit indices
    localparam int CTRL_EN       = 0;
    localparam int CTRL_IE       = 1;
    localparam int CTRL_PERIODIC = 2;

    // STATUS bit indices
    localparam int STAT_PEND = 0;

    // Byte address with the ignored low bits forced to zero
    function automatic logic [4:0] word_addr(input logic [4:0] addr);
        return {addr[4:2], 2'b00};
    endfunction

endpackage

// File: rtl/timer_irq_gen_if.sv
// rtl/timer_irq_gen_if.sv - data-memory bus bundle for the timer register block
// Signals:
//   bus_we    - write strobe, one cycle per access
//   bus_re    - read strobe, one cycle per access
//   bus_addr  - byte address, bits [1:0] ignored
//   bus_wdata - write data
//   bus_rdata - registered read data (one cycle latency)
interface timer_bus_if;
    logic        bus_we;
    logic        bus_re;
    logic [4:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;

    modport master (output bus_we, bus_re, bus_addr, bus_wdata, input bus_rdata);
    modport slave  (input bus_we, bus_re, bus_addr, bus_wdata, output bus_rdata);
endinterface

// File: rtl/timer_prescaler.sv
// rtl/timer_prescaler.sv - divides the clock into one-cycle ticks every presc+1 cycles
// Ports:
//   clk, rst - clock, asynchronous active-high reset
//   en       - run enable; counter is held at zero while low
//   presc    - terminal count; tick fires when the counter equals it
//   tick     - one-cycle pulse, combinational from the counter flop
module timer_prescaler #(
    parameter int PRESC_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);

    logic [PRESC_W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = en && (cnt_q == presc);
        cnt_d = '0;
        if (en && !tick) begin
            cnt_d = cnt_q + PRESC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/timer_irq_gen.sv
// rtl/timer_irq_gen.sv - memory-mapped machine timer raising a level timer interrupt
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   bus         - timer_bus_if.slave register access (CTRL, COUNT, CMP, STATUS, PRESC)
//   irq_done_i  - handler-complete acknowledge, clears PEND
//   irq_timer_o - level interrupt request, PEND & IE
// Build option TIMER_PERIODIC_EN: implements CTRL.PERIODIC (auto-reload of COUNT
// to zero on match); when undefined the bit is not stored and reads zero.
module timer_irq_gen
    import timer_pkg::*;
#(
    parameter int                 CNT_W     = 32,
    parameter int                 PRESC_W   = 16,
    parameter logic [CNT_W-1:0]   RESET_CMP = {CNT_W{1'b1}}
) (
    input  logic         clk,
    input  logic         rst,
    timer_bus_if.slave   bus,
    input  logic         irq_done_i,
    output logic         irq_timer_o
);

    logic               en_q, en_d, ie_q, ie_d, pend_q, pend_d;
    logic [CNT_W-1:0]   count_q, count_d, cmp_q, cmp_d, count_next;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [4:0]         waddr;
    logic               wr_ctrl, wr_count, wr_cmp, wr_status, wr_presc;
    logic               tick, match, periodic;

    assign waddr     = word_addr(bus.bus_addr);
    assign wr_ctrl   = bus.bus_we && (waddr == TMR_CTRL);
    assign wr_count  = bus.bus_we && (waddr == TMR_COUNT);
    assign wr_cmp    = bus.bus_we && (waddr == TMR_CMP);
    assign wr_status = bus.bus_we && (waddr == TMR_STATUS);
    assign wr_presc  = bus.bus_we && (waddr == TMR_PRESC);

`ifdef TIMER_PERIODIC_EN
    logic per_q, per_d;
    always_comb begin
        per_d = per_q;
        if (wr_ctrl) begin
            per_d = bus.bus_wdata[CTRL_PERIODIC];
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            per_q <= 1'b0;
        end else begin
            per_q <= per_d;
        end
    end
    assign periodic = per_q;
`else
    assign periodic = 1'b0;
`endif

    // The prescaler only runs while EN is set both before and after this edge:
    // the enabling edge starts from zero, and a disabling write zeroes it at once.
    timer_prescaler #(.PRESC_W(PRESC_W)) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .en    (en_q && en_d),
        .presc (presc_q),
        .tick  (tick)
    );

    assign count_next = count_q + CNT_W'(1);
    // Compare uses the pre-write CMP, so a same-cycle CMP write affects later ticks only.
    assign match      = tick && (count_next == cmp_q);

    always_comb begin
        en_d    = en_q;
        ie_d    = ie_q;
        count_d = count_q;
        cmp_d   = cmp_q;
        presc_d = presc_q;
        pend_d  = pend_q;
        rdata_d = rdata_q;

        if (tick) begin
            count_d = (match && periodic) ? '0 : count_next;
        end

        if (wr_ctrl) begin
            en_d = bus.bus_wdata[CTRL_EN];
            ie_d = bus.bus_wdata[CTRL_IE];
        end
        // Software COUNT write overrides the tick update on the same edge.
        if (wr_count) count_d = CNT_W'(bus.bus_wdata);
        if (wr_cmp)   cmp_d   = CNT_W'(bus.bus_wdata);
        if (wr_presc) presc_d = PRESC_W'(bus.bus_wdata);

        // Set has priority over clear so a match coinciding with an ack is kept.
        if (match) begin
            pend_d = 1'b1;
        end else if ((irq_done_i && pend_q) || (wr_status && bus.bus_wdata[STAT_PEND])) begin
            pend_d = 1'b0;
        end

        // Read mux looks at current flops, so a same-cycle write is not yet visible.
        if (bus.bus_re) begin
            case (waddr)
                TMR_CTRL:   rdata_d = {29'b0, periodic, ie_q, en_q};
                TMR_COUNT:  rdata_d = 32'(count_q);
                TMR_CMP:    rdata_d = 32'(cmp_q);
                TMR_STATUS: rdata_d = {31'b0, pend_q};
                TMR_PRESC:  rdata_d = 32'(presc_q);
                default:    rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q    <= 1'b0;
            ie_q    <= 1'b0;
            count_q <= '0;
            cmp_q   <= RESET_CMP;
            presc_q <= '0;
            pend_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            en_q    <= en_d;
            ie_q    <= ie_d;
            count_q <= count_d;
            cmp_q   <= cmp_d;
            presc_q <= presc_d;
            pend_q  <= pend_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.bus_rdata = rdata_q;
    assign irq_timer_o   = pend_q & ie_q;

endmodule

// File: tb/tb_timer_irq_gen.sv
// tb/tb_timer_irq_gen.sv - self-checking bench for timer_irq_gen
module tb_timer_irq_gen;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic irq_done = 1'b0;
    logic irq;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   armed = 0;

    timer_bus_if bus ();

    timer_irq_gen dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .irq_done_i  (irq_done),
        .irq_timer_o (irq)
    );

    always #5 clk = ~clk;

`ifdef TIMER_PERIODIC_EN
    localparam logic [2:0] CTRL_MASK = 3'b111;
`else
    localparam logic [2:0] CTRL_MASK = 3'b011;
`endif

    // Reference model: register contents and prescale phase per the register rules
    logic [2:0]  m_ctrl;
    logic [31:0] m_count, m_cmp, m_rdata;
    logic [15:0] m_presc, m_phase;
    logic        m_pend;
    logic        m_running, m_tick, m_hit, m_clear;
    int          m_wa;

    function automatic logic [31:0] m_reg(input logic [4:0] a);
        case (a[4:2])
            3'd0:    return {29'b0, m_ctrl};
            3'd1:    return m_count;
            3'd2:    return m_cmp;
            3'd3:    return {31'b0, m_pend};
            3'd4:    return {16'b0, m_presc};
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ctrl = '0; m_count = '0; m_cmp = 32'hFFFF_FFFF; m_pend = 1'b0;
            m_presc = '0; m_phase = '0; m_rdata = '0;
        end else begin
            m_wa = bus.bus_we ? int'(bus.bus_addr[4:2]) : -1;
            if (bus.bus_re) m_rdata = m_reg(bus.bus_addr);
            m_running = m_ctrl[0] && !(m_wa == 0 && !bus.bus_wdata[0]);
            m_tick    = m_running && (m_phase == m_presc);
            m_phase   = (m_running && !m_tick) ? m_phase + 16'd1 : 16'd0;
            m_hit     = m_tick && ((m_count + 32'd1) == m_cmp);
            if (m_tick) m_count = (m_hit && m_ctrl[2]) ? 32'd0 : m_count + 32'd1;
            m_clear = (irq_done && m_pend) || (m_wa == 3 && bus.bus_wdata[0]);
            if (m_hit) m_pend = 1'b1;
            else if (m_clear) m_pend = 1'b0;
            case (m_wa)
                0: m_ctrl  = bus.bus_wdata[2:0] & CTRL_MASK;
                1: m_count = bus.bus_wdata;
                2: m_cmp   = bus.bus_wdata;
                4: m_presc = bus.bus_wdata[15:0];
                default: ;
            endcase
        end
    end

    // Per-cycle comparison of outputs against the model
    always @(negedge clk) begin
        if (armed && !rst) begin
            n_cmp++;
            if (irq !== (m_pend & m_ctrl[1])) begin
                n_bad++;
                $display("FAIL model_irq t=%0t: got %b want %b", $time, irq, m_pend & m_ctrl[1]);
            end
            n_cmp++;
            if (bus.bus_rdata !== m_rdata) begin
                n_bad++;
                $display("FAIL model_rdata t=%0t: got %h want %h", $time, bus.bus_rdata, m_rdata);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus.bus_we = 1'b1; bus.bus_addr = a; bus.bus_wdata = d;
        step();
        bus.bus_we = 1'b0;
    endtask

    task automatic rd(input string name, input logic [4:0] a, input logic [31:0] exp);
        bus.bus_re = 1'b1; bus.bus_addr = a;
        step();
        bus.bus_re = 1'b0;
        chk(name, bus.bus_rdata, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        bus.bus_we = 1'b0; bus.bus_re = 1'b0; bus.bus_addr = '0; bus.bus_wdata = '0;
        step();
        do_reset();
        armed = 1;

        // Reset values
        chk("reset_irq", {31'b0, irq}, 32'h0);
        chk("reset_rdata", bus.bus_rdata, 32'h0);
        rd("reset_ctrl", 5'h00, 32'h0);
        rd("reset_cmp", 5'h08, 32'hFFFF_FFFF);
        rd("reset_status", 5'h0C, 32'h0);

        // PRESC=0, CMP=5: match on the 5th tick edge after enabling
        wr(5'h10, 32'd0);
        wr(5'h08, 32'd5);
        wr(5'h00, 32'h3);
        repeat (4) step();
        chk("t1_irq_before", {31'b0, irq}, 32'h0);
        step();
        chk("t1_irq_at_match", {31'b0, irq}, 32'h1);
        rd("t1_count", 5'h04, 32'd5);

        // PRESC=3, CMP=2: ticks every 4 cycles, irq 8 cycles after enable
        do_reset();
        wr(5'h10, 32'd3);
        wr(5'h08, 32'd2);
        wr(5'h00, 32'h3);
        repeat (7) step();
        chk("t2_irq_before", {31'b0, irq}, 32'h0);
        step();
        chk("t2_irq_at_match", {31'b0, irq}, 32'h1);

        // Acknowledge paths
        irq_done = 1'b1;
        step();
        irq_done = 1'b0;
        chk("t3_done_clears", {31'b0, irq}, 32'h0);
        wr(5'h04, 32'd1);
        repeat (5) step();
        chk("t3_rematch", {31'b0, irq}, 32'h1);
        wr(5'h0C, 32'h1);
        chk("t3_w1c_clears", {31'b0, irq}, 32'h0);
        wr(5'h04, 32'd1);
        repeat (5) step();
        chk("t3_rematch2", {31'b0, irq}, 32'h1);
        wr(5'h0C, 32'h0);
        chk("t3_w0_holds", {31'b0, irq}, 32'h1);
        rd("t3_status", 5'h0C, 32'h1);

        // Periodic auto-reload, or free-running when the option is absent
        do_reset();
        wr(5'h08, 32'd3);
        wr(5'h00, 32'h7);
`ifdef TIMER_PERIODIC_EN
        rd("t4_c0", 5'h04, 32'd0);
        rd("t4_c1", 5'h04, 32'd1);
        rd("t4_c2", 5'h04, 32'd2);
        rd("t4_c3", 5'h04, 32'd0);
        rd("t4_c4", 5'h04, 32'd1);
        rd("t4_c5", 5'h04, 32'd2);
        irq_done = 1'b1;
        step();
        step();
        chk("t4_done_cleared", {31'b0, irq}, 32'h0);
        step();
        irq_done = 1'b0;
        chk("t4_set_wins", {31'b0, irq}, 32'h1);
        rd("t4_ctrl", 5'h00, 32'h7);
`else
        rd("t4_c0", 5'h04, 32'd0);
        rd("t4_c1", 5'h04, 32'd1);
        rd("t4_c2", 5'h04, 32'd2);
        rd("t4_c3", 5'h04, 32'd3);
        rd("t4_c4", 5'h04, 32'd4);
        rd("t4_c5", 5'h04, 32'd5);
        rd("t4_ctrl", 5'h00, 32'h3);
`endif

        // Wrap through all-ones without interrupt, then match at 0x10
        do_reset();
        wr(5'h08, 32'h10);
        wr(5'h04, 32'hFFFF_FFFE);
        wr(5'h00, 32'h3);
        repeat (17) step();
        chk("t5_no_irq_on_wrap", {31'b0, irq}, 32'h0);
        step();
        chk("t5_irq_at_0x10", {31'b0, irq}, 32'h1);
        rd("t5_count", 5'h04, 32'h10);

        // Same-cycle write and read returns the old value
        bus.bus_we = 1'b1; bus.bus_re = 1'b1; bus.bus_addr = 5'h08; bus.bus_wdata = 32'h55;
        step();
        bus.bus_we = 1'b0; bus.bus_re = 1'b0;
        chk("t6_rw_old", bus.bus_rdata, 32'h10);
        rd("t6_rw_new", 5'h08, 32'h55);

        // Unmapped addresses and ignored low address bits
        wr(5'h18, 32'hFFFF_FFFF);
        rd("t7_unmapped_14", 5'h14, 32'h0);
        rd("t7_unmapped_18", 5'h1A, 32'h0);
        rd("t7_low_bits", 5'h0B, 32'h55);

        // Asynchronous reset mid-interrupt
        chk("t8_irq_before_rst", {31'b0, irq}, 32'h1);
        rst = 1'b1;
        #1;
        chk("t8_irq_async_drop", {31'b0, irq}, 32'h0);
        chk("t8_rdata_async", bus.bus_rdata, 32'h0);
        step();
        rst = 1'b0;
        rd("t8_count", 5'h04, 32'h0);
        rd("t8_cmp", 5'h08, 32'hFFFF_FFFF);
        rd("t8_ctrl", 5'h00, 32'h0);
        rd("t8_presc", 5'h10, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/timer_irq_gen.md
# timer_irq_gen

Memory-mapped machine-timer peripheral that is the source side of the core's timer interrupt line. It counts prescaled clock ticks, compares against a programmable value, and raises a level-sensitive `irq_timer_o` into the interrupt controller's timer input. The line is held until the handler acknowledges through `irq_done_i` or a software write-1-to-clear. It sits on the data-memory bus next to the pipeline's load/store unit.

## Interface

Parameters:
- `CNT_W`, 32 — width of the COUNT and CMP registers.
- `PRESC_W`, 16 — width of the PRESC register and the prescale counter.
- `RESET_CMP`, 32'hFFFF_FFFF — reset value of CMP.

Ports:
- `clk` input 1 — single clock.
- `rst` input 1 — asynchronous, active-high reset.
- `bus_we` input 1 — write strobe, one cycle per access.
- `bus_re` input 1 — read strobe, one cycle per access.
- `bus_addr` input 5 — byte address, word aligned; bits [1:0] are ignored.
- `bus_wdata` input 32 — write data.
- `bus_rdata` output 32 — registered read data.
- `irq_done_i` input 1 — handler-complete acknowledge from the interrupt controller; sampled high for one cycle.
- `irq_timer_o` output 1 — level interrupt request to the controller.

## Operation

- Registers:
  - 0x00 CTRL: bit0 EN, bit1 IE, bit2 PERIODIC.
  - 0x04 COUNT.
  - 0x08 CMP.
  - 0x0C STATUS: bit0 PEND, write-1-to-clear.
  - 0x10 PRESC.
- Reset values: CTRL=0, COUNT=0, CMP=`RESET_CMP`, PEND=0, PRESC=0, prescale counter=0, `bus_rdata`=0, `irq_timer_o`=0.
- Prescaler:
  - When EN=1, the prescale counter increments each cycle.
  - When it equals PRESC, a one-cycle tick is generated and the counter returns to 0.
  - When EN=0, the prescale counter is held at 0 and no ticks are generated.
- On tick, compute `next = COUNT + 1` modulo 2^CNT_W (wraps silently from all-ones to 0).
  - If `next == CMP`: set PEND. In PERIODIC mode, COUNT loads 0; otherwise COUNT loads `next`.
  - Else: COUNT loads `next`.
- `irq_timer_o = PEND & IE`, driven from flops only, with no combinational path from bus inputs.
- PEND clears when `irq_done_i`=1 while PEND=1, or on a STATUS write with bit0=1. Writing STATUS bit0=0 has no effect.
- Unmapped addresses read 0; writes to them are ignored. Reserved CTRL/STATUS bits read 0.

## Timing

- Tick period is PRESC+1 cycles. PRESC=0 gives a tick every cycle.
- PEND and `irq_timer_o` rise on the clock edge that processes the matching tick.
- Read latency is 1: `bus_rdata` is valid the cycle after `bus_re` and holds its value until the next read.
- A write takes effect on the edge where `bus_we` is sampled, and the new value is visible to a read issued the following cycle.
- Simultaneous events:
  - Software write to COUNT on the same cycle as a tick: the write wins and the tick's COUNT update is discarded. A match on that tick still sets PEND.
  - PEND set (match) and clear (`irq_done_i` or W1C) on the same cycle: set wins, so no event is lost.
  - Write to CMP on a tick cycle: the compare uses the old CMP.
  - CTRL write with EN 1→0: the prescale counter returns to 0 on the same edge. COUNT and PEND hold their values.
  - `bus_we` and `bus_re` to the same address on the same cycle: the read returns the pre-write value.
- `rst` asserted mid-count or mid-interrupt returns all state to reset values immediately, with no clock needed. `irq_timer_o` drops asynchronously.

## Configuration

- `TIMER_PERIODIC_EN`:
  - Defined: CTRL.PERIODIC is implemented and auto-reload behaves as described in Operation.
  - Undefined: bit2 is not stored, reads 0, and writes are ignored. The timer is always one-shot/free-running, so COUNT continues past CMP and wraps.

## Structure

- Shared package `timer_pkg`:
  - Register offsets `TMR_CTRL`, `TMR_COUNT`, `TMR_CMP`, `TMR_STATUS`, `TMR_PRESC`.
  - CTRL bit indices `CTRL_EN`, `CTRL_IE`, `CTRL_PERIODIC`.
  - STATUS bit index `STAT_PEND`.
- Sub-module `timer_prescaler`:
  - Ports: `clk`, `rst`, `en`, `presc[PRESC_W-1:0]`, `tick`.
  - Instantiated once.
- Register file, compare logic, and pending logic live in the top module.

## Test plan

- Reset, then PRESC=0, CMP=5, CTRL=0x3: PEND and `irq_timer_o` rise on the 5th tick edge after the CTRL write; COUNT reads 5.
- PRESC=3, CMP=2, CTRL=0x3: ticks arrive every 4 cycles; `irq_timer_o` asserts 8 cycles after enable.
- With `irq_timer_o`=1, pulse `irq_done_i`: output low the next cycle. Then repeat with a STATUS write of 0x1: same result. A STATUS write of 0x0 leaves PEND set.
- With `TIMER_PERIODIC_EN` defined, CTRL=0x7, CMP=3, PRESC=0: COUNT sequence is 1,2,0,1,2,0…; PEND is re-set every 3 cycles, and an `irq_done_i` coinciding with a match leaves PEND=1.
- COUNT=0xFFFF_FFFE, CMP=0x10, PRESC=0, EN=1: COUNT wraps to 0 with no interrupt, then matches at 0x10. Separately, assert `rst` mid-count: all registers return to reset values and `irq_timer_o`=0 immediately.
